coin_controller: RTL and testbench

Owns the life cycle of one collectible coin: spawn position, spin animation, collection by the player and respawn. It drives the coin sprite generator's position and animation-frame inputs, and consumes that generator's collision result. It produces the collection pulse and score consumed by the HUD and sound logic. It runs in the pixel clock domain and updates once per video frame, except that collection is taken on any cycle.

---
 rtl/coin_controller.sv | 191 +++++++++++++++++++
 tb/tb_coin_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/coin_controller.sv
// Coin life cycle: spin, collection, off-screen miss and respawn.
// Optional COIN_LFSR_EN picks respawn lanes from an 8-bit LFSR.
module coin_controller #(
  parameter int WIDTH          = 16,
  parameter int ANIM_DIV       = 8,
  parameter int RESPAWN_FRAMES = 60,
  parameter int SPAWN_AHEAD    = 640
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        frame_in,
  input  logic        collision_info,
  input  logic [11:0] offset_background,
  input  logic        reset_signal,
  output logic [12:0] x_out,
  output logic [9:0]  y_out,
  output logic [1:0]  unique_image_index,
  output logic        coin_visible,
  output logic        coin_effect,
  output logic [7:0]  coin_count
);

  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int RW = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);
  localparam logic [RW-1:0] RESP_LAST = RW'(RESPAWN_FRAMES - 1);
  localparam logic [13:0]   W14       = 14'(WIDTH);
  localparam logic [12:0]   AHEAD     = 13'(SPAWN_AHEAD);

  typedef enum logic [1:0] {
    ACTIVE,
    COLLECTED,
    RESPAWN
  } state_t;

  state_t        state_q, state_d;
  logic [12:0]   x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [1:0]    img_q, img_d;
  logic          vis_q, vis_d;
  logic          fx_q, fx_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW-1:0] anim_q, anim_d;
  logic [RW-1:0] resp_q, resp_d;
  logic [1:0]    spin_q, spin_d;

  logic          rst;
  logic          off_screen;
  logic          respawn_now;
  logic [12:0]   spawn_x;
  logic [1:0]    spawn_sel;

  assign rst         = rst_in | reset_signal;
  assign off_screen  = ({1'b0, x_q} + W14) <= {2'b00, offset_background};
  assign spawn_x     = {1'b0, offset_background} + AHEAD;
  assign respawn_now = (state_q == RESPAWN) & frame_in & (resp_q == RESP_LAST);

  function automatic logic [9:0] lane_y(input logic [1:0] s);
    logic [9:0] y;
    unique case (s)
      2'd0: y = 10'd40;
      2'd1: y = 10'd112;
      2'd2: y = 10'd176;
      2'd3: y = 10'd208;
    endcase
    return y;
  endfunction

`ifdef COIN_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       lfsr_fb;

  assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign lfsr_d    = frame_in ? {lfsr_q[6:0], lfsr_fb} : lfsr_q;
  assign spawn_sel = lfsr_q[1:0];

  // LFSR steps on every video frame regardless of state
  always_ff @(posedge pixel_clk_in) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end
`else
  logic [1:0] sel_q, sel_d;

  assign spawn_sel = sel_q + 2'd1;
  assign sel_d     = respawn_now ? spawn_sel : sel_q;

  // Round-robin lane pointer, advanced at each respawn
  always_ff @(posedge pixel_clk_in) begin
    if (rst) sel_q <= 2'd1;
    else     sel_q <= sel_d;
  end
`endif

  // State and output registers; reset beats every other event
  always_ff @(posedge pixel_clk_in) begin
    if (rst) begin
      state_q <= ACTIVE;
      x_q     <= 13'd640;
      y_q     <= 10'd112;
      img_q   <= 2'd0;
      vis_q   <= 1'b1;
      fx_q    <= 1'b0;
      cnt_q   <= 8'd0;
      anim_q  <= '0;
      resp_q  <= '0;
      spin_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      img_q   <= img_d;
      vis_q   <= vis_d;
      fx_q    <= fx_d;
      cnt_q   <= cnt_d;
      anim_q  <= anim_d;
      resp_q  <= resp_d;
      spin_q  <= spin_d;
    end
  end

  // Next-state: collision outranks frame events while ACTIVE
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    img_d   = img_q;
    vis_d   = vis_q;
    fx_d    = 1'b0;
    cnt_d   = cnt_q;
    anim_d  = anim_q;
    resp_d  = resp_q;
    spin_d  = spin_q;
    unique case (state_q)
      ACTIVE: begin
        if (collision_info) begin
          state_d = COLLECTED;
          fx_d    = 1'b1;
          anim_d  = '0;
          spin_d  = 2'd0;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else if (frame_in) begin
          if (off_screen) begin
            state_d = RESPAWN;
            vis_d   = 1'b0;
            anim_d  = '0;
            resp_d  = '0;
          end else if (anim_q == ANIM_LAST) begin
            anim_d = '0;
            img_d  = img_q + 2'd1;
          end else begin
            anim_d = anim_q + 1'b1;
          end
        end
      end
      COLLECTED: begin
        if (frame_in) begin
          img_d  = img_q + 2'd1;
          spin_d = spin_q + 2'd1;
          if (spin_q == 2'd3) begin
            state_d = RESPAWN;
            vis_d   = 1'b0;
            resp_d  = '0;
          end
        end
      end
      RESPAWN: begin
        if (respawn_now) begin
          state_d = ACTIVE;
          x_d     = spawn_x;
          y_d     = lane_y(spawn_sel);
          img_d   = 2'd0;
          vis_d   = 1'b1;
          anim_d  = '0;
          resp_d  = '0;
        end else if (frame_in) begin
          resp_d = resp_q + 1'b1;
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  assign x_out              = x_q;
  assign y_out              = y_q;
  assign unique_image_index = img_q;
  assign coin_visible       = vis_q;
  assign coin_effect        = fx_q;
  assign coin_count         = cnt_q;

endmodule

// File: tb/tb_coin_controller.sv
// Bench for coin_controller: behavioural model checked every cycle
// plus literal expectations for reset, animation, collection, miss.
module tb_coin_controller;

  localparam int WIDTH          = 16;
  localparam int ANIM_DIV       = 8;
  localparam int RESPAWN_FRAMES = 60;
  localparam int SPAWN_AHEAD    = 640;

  localparam int LIVE   = 0;
  localparam int SPIN   = 1;
  localparam int HIDDEN = 2;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        frame_in = 1'b0;
  logic        collision_info = 1'b0;
  logic [11:0] offset_background = 12'd0;
  logic        reset_signal = 1'b0;
  logic [12:0] x_out;
  logic [9:0]  y_out;
  logic [1:0]  unique_image_index;
  logic        coin_visible;
  logic        coin_effect;
  logic [7:0]  coin_count;

  always #5 clk = ~clk;

  coin_controller #(
    .WIDTH(WIDTH),
    .ANIM_DIV(ANIM_DIV),
    .RESPAWN_FRAMES(RESPAWN_FRAMES),
    .SPAWN_AHEAD(SPAWN_AHEAD)
  ) dut (
    .pixel_clk_in(clk),
    .rst_in(rst_in),
    .frame_in(frame_in),
    .collision_info(collision_info),
    .offset_background(offset_background),
    .reset_signal(reset_signal),
    .x_out(x_out),
    .y_out(y_out),
    .unique_image_index(unique_image_index),
    .coin_visible(coin_visible),
    .coin_effect(coin_effect),
    .coin_count(coin_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  int m_valid = 0;
  int m_phase, m_x, m_y, m_img, m_vis, m_fx, m_cnt;
  int m_anim, m_spin, m_hid, m_lane;
  int lanes[4] = '{40, 112, 176, 208};
`ifdef COIN_LFSR_EN
  int m_lfsr;
`endif

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_step(input int frm, input int col,
                            input int off, input int rst);
    int pick;
    if (rst != 0) begin
      m_valid = 1;
      m_phase = LIVE;
      m_x = 640; m_y = 112; m_img = 0; m_vis = 1;
      m_fx = 0; m_cnt = 0; m_anim = 0; m_spin = 0; m_hid = 0;
      m_lane = 1;
`ifdef COIN_LFSR_EN
      m_lfsr = 'hA5;
`endif
      return;
    end
    m_fx = 0;
    pick = (m_lane + 1) % 4;
`ifdef COIN_LFSR_EN
    pick = m_lfsr % 4;
    if (frm != 0)
      m_lfsr = ((m_lfsr << 1) & 255) |
               (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1);
`endif
    if (m_phase == LIVE) begin
      if (col != 0) begin
        m_phase = SPIN; m_fx = 1; m_anim = 0; m_spin = 0;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end else if (frm != 0) begin
        if (m_x + WIDTH <= off) begin
          m_phase = HIDDEN; m_vis = 0; m_hid = 0; m_anim = 0;
        end else begin
          m_anim++;
          if (m_anim == ANIM_DIV) begin
            m_anim = 0;
            m_img = (m_img + 1) % 4;
          end
        end
      end
    end else if (m_phase == SPIN) begin
      if (frm != 0) begin
        m_img = (m_img + 1) % 4;
        m_spin++;
        if (m_spin == 4) begin
          m_phase = HIDDEN; m_vis = 0; m_hid = 0;
        end
      end
    end else begin
      if (frm != 0) begin
        m_hid++;
        if (m_hid == RESPAWN_FRAMES) begin
          m_phase = LIVE; m_hid = 0; m_anim = 0;
          m_x = (off + SPAWN_AHEAD) % 8192;
          m_lane = pick;
          m_y = lanes[pick];
          m_img = 0; m_vis = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    if (m_valid == 0) return;
    chk("x_out", int'(x_out), m_x);
    chk("y_out", int'(y_out), m_y);
    chk("unique_image_index", int'(unique_image_index), m_img);
    chk("coin_visible", int'(coin_visible), m_vis);
    chk("coin_effect", int'(coin_effect), m_fx);
    chk("coin_count", int'(coin_count), m_cnt);
  endtask

  task automatic cyc(input int frm, input int col, input int off,
                     input int rst, input int rsig);
    frame_in          = (frm != 0);
    collision_info    = (col != 0);
    offset_background = 12'(off);
    rst_in            = (rst != 0);
    reset_signal      = (rsig != 0);
    @(posedge clk);
    model_step(frm, col, off, ((rst != 0) || (rsig != 0)) ? 1 : 0);
    #1;
    compare_all();
    if (coin_effect) pulses++;
  endtask

  task automatic frames(input int n, input int off);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, off, 0, 0);
      cyc(0, 0, off, 0, 0);
    end
  endtask

  initial begin
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("rst x", int'(x_out), 640);
    chk("rst y", int'(y_out), 112);
    chk("rst img", int'(unique_image_index), 0);
    chk("rst vis", int'(coin_visible), 1);
    chk("rst count", int'(coin_count), 0);
    chk("rst effect", int'(coin_effect), 0);
    cyc(0, 0, 0, 0, 0);

    frames(16, 0);
    chk("anim16 img", int'(unique_image_index), 2);
    frames(16, 0);
    chk("anim32 img", int'(unique_image_index), 0);

    pulses = 0;
    repeat (5) cyc(0, 1, 0, 0, 0);
    chk("collect pulses", pulses, 1);
    chk("collect count", int'(coin_count), 1);
    cyc(0, 0, 0, 0, 0);
    frames(4, 0);
    chk("spin done vis", int'(coin_visible), 0);
    frames(59, 100);
    chk("hidden59 vis", int'(coin_visible), 0);
    frames(1, 100);
    chk("respawn x", int'(x_out), 740);
    chk("respawn vis", int'(coin_visible), 1);
    chk("respawn img", int'(unique_image_index), 0);
`ifndef COIN_LFSR_EN
    chk("respawn y", int'(y_out), 176);
`endif

    frames(7, 100);
    chk("pre-sim img", int'(unique_image_index), 0);
    cyc(1, 1, 100, 0, 0);
    chk("sim effect", int'(coin_effect), 1);
    chk("sim img", int'(unique_image_index), 0);
    chk("sim count", int'(coin_count), 2);
    cyc(0, 0, 100, 0, 0);
    chk("sim effect drop", int'(coin_effect), 0);
    frames(4, 0);
    frames(60, 0);
    chk("respawn2 x", int'(x_out), 640);

    frames(1, 655);
    chk("edge 655 vis", int'(coin_visible), 1);
    frames(1, 656);
    chk("miss vis", int'(coin_visible), 0);
    chk("miss count", int'(coin_count), 2);
    pulses = 0;
    repeat (4) cyc(0, 1, 656, 0, 0);
    chk("hidden col pulses", pulses, 0);
    chk("hidden col count", int'(coin_count), 2);
    frames(60, 0);
    chk("respawn3 vis", int'(coin_visible), 1);

    pulses = 0;
    for (int k = 0; k < 256; k++) begin
      cyc(0, 1, 0, 0, 0);
      repeat (64) cyc(1, 0, 0, 0, 0);
    end
    chk("sat count", int'(coin_count), 255);
    chk("sat pulses", pulses, 256);

    cyc(0, 1, 0, 0, 0);
    repeat (14) cyc(1, 0, 0, 0, 0);
    chk("mid hidden vis", int'(coin_visible), 0);
    cyc(0, 1, 0, 0, 1);
    chk("restart x", int'(x_out), 640);
    chk("restart y", int'(y_out), 112);
    chk("restart vis", int'(coin_visible), 1);
    chk("restart count", int'(coin_count), 0);
    chk("restart effect", int'(coin_effect), 0);
    cyc(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
